counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 129 ++++++++++++
 tb/tb_counter_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that grants a shared up-counter to one requester at a time.
// The counter runs from 0 to the latched length, then the owner gets a one-cycle done pulse.
module counter_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [CW-1:0]      count,
    output logic [NREQ-1:0]    done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // state  | meaning
    // S_IDLE | no owner; arbitrate among req each cycle
    // S_RUN  | owner holds the counter until count==len_lat or it drops req
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   w_win;
    logic            w_any;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_len_lat;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_done_nxt;
    logic            w_owner_req;
    logic            w_at_end;
    logic            w_finish;

    // Scan downward in priority so the nearest requester after r_ptr is written last.
    always_comb begin
        w_win = r_ptr;
        w_any = |req;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(r_ptr) + k) % NREQ]) begin
                w_win = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_owner_req = req[r_owner];
    assign w_at_end    = (r_count == r_len_lat);
    assign w_finish    = (r_state == S_RUN) && w_owner_req && w_at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_owner_req || w_at_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt      = '0;
        w_done_nxt = '0;
        if (r_state == S_RUN) begin
            w_gnt[r_owner] = 1'b1;
        end
        if (w_finish) begin
            w_done_nxt[r_owner] = 1'b1;
        end
    end

    // ptr only moves at grant, so an aborted owner still ends up lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= PW'(NREQ - 1);
            r_owner   <= '0;
            r_count   <= '0;
            r_len_lat <= '0;
            r_done    <= '0;
        end else begin
            r_done <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    if (w_any) begin
                        r_owner   <= w_win;
                        r_ptr     <= w_win;
                        r_len_lat <= len[w_win*CW +: CW];
                    end
                end
                S_RUN: begin
                    if (w_owner_req && !w_at_end) begin
                        r_count <= r_count + 1'b1;
                    end else begin
                        r_count <= '0;
                    end
                end
                default: r_count <= '0;
            endcase
        end
    end

    assign gnt   = w_gnt;
    assign busy  = (r_state == S_RUN);
    assign count = r_count;
    assign done  = r_done;

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them, and requires a quiet bus on all other cycles.
module tb_counter_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  count;
    logic [3:0]  done;

    counter_arbiter #(.NREQ(4), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [3:0] cnt;
        logic [3:0] done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   mon_on  = 1'b0;

    task automatic push(input int c, input logic [3:0] g, input logic [3:0] cn, input logic [3:0] d);
        exp_t e;
        e.cyc  = c;
        e.gnt  = g;
        e.cnt  = cn;
        e.done = d;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                n_total++;
                $display("FAIL missed_expect cyc=%0d expected entry for cyc %0d never sampled", cyc, mon_e.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                n_total++;
                if (gnt === mon_e.gnt && count === mon_e.cnt && done === mon_e.done &&
                    busy === (mon_e.gnt != 4'b0000))
                    n_pass++;
                else
                    $display("FAIL outputs cyc=%0d got gnt=%b count=%0d done=%b busy=%b want gnt=%b count=%0d done=%b busy=%b",
                             cyc, gnt, count, done, busy, mon_e.gnt, mon_e.cnt, mon_e.done, (mon_e.gnt != 4'b0000));
            end else begin
                n_total++;
                if (gnt === 4'b0000 && done === 4'b0000 && busy === 1'b0 && count === 4'd0)
                    n_pass++;
                else
                    $display("FAIL idle_quiet cyc=%0d got gnt=%b count=%0d done=%b busy=%b want all zero",
                             cyc, gnt, count, done, busy);
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1;
        req = 4'b0000;
        len = 16'h0000;
        #12 rst = 1'b0;
        step(1);
        mon_on = 1'b1;
        t = cyc;
        push(t, 4'b0000, 4'd0, 4'b0000);

        // Round robin from reset: all requesting, all len=0.
        step(1);
        t = cyc;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push(t + 1 + 2*i, 4'b0001 << (i % 4), 4'd0, 4'b0000);
            push(t + 2 + 2*i, 4'b0000, 4'd0, 4'b0001 << (i % 4));
        end
        step(10);
        req = 4'b0000;
        step(2);

        // Single request, len[0]=3.
        t = cyc;
        len[3:0] = 4'd3;
        req = 4'b0001;
        for (int i = 0; i < 4; i++) push(t + 1 + i, 4'b0001, 4'(i), 4'b0000);
        push(t + 5, 4'b0000, 4'd0, 4'b0001);
        step(5);
        req = 4'b0000;
        step(2);

        // Abort requester 2 at count=4, then 0110 must grant requester 1.
        t = cyc;
        len[11:8] = 4'd9;
        req = 4'b0100;
        for (int i = 0; i < 5; i++) push(t + 1 + i, 4'b0100, 4'(i), 4'b0000);
        push(t + 6, 4'b0000, 4'd0, 4'b0000);
        push(t + 7, 4'b0010, 4'd0, 4'b0000);
        push(t + 8, 4'b0000, 4'd0, 4'b0000);
        step(5);
        req = 4'b0000;
        step(1);
        req = 4'b0110;
        step(1);
        req = 4'b0000;
        step(2);

        // Maximum length on requester 1: count 0..15, no wrap.
        t = cyc;
        len[7:4] = 4'd15;
        req = 4'b0010;
        for (int i = 0; i < 16; i++) push(t + 1 + i, 4'b0010, 4'(i), 4'b0000);
        push(t + 17, 4'b0000, 4'd0, 4'b0010);
        step(17);
        req = 4'b0000;
        step(2);

        // len[3] changed from 2 to 7 while running; latched value must hold.
        t = cyc;
        len[15:12] = 4'd2;
        req = 4'b1000;
        push(t + 1, 4'b1000, 4'd0, 4'b0000);
        push(t + 2, 4'b1000, 4'd1, 4'b0000);
        push(t + 3, 4'b1000, 4'd2, 4'b0000);
        push(t + 4, 4'b0000, 4'd0, 4'b1000);
        step(2);
        len[15:12] = 4'd7;
        step(2);
        req = 4'b0000;
        step(2);

        // Async reset mid-interval on requester 0 at count=5, then 0011 must grant 0.
        t = cyc;
        len[3:0] = 4'd9;
        req = 4'b0001;
        for (int i = 0; i < 5; i++) push(t + 1 + i, 4'b0001, 4'(i), 4'b0000);
        step(6);
        rst = 1'b1;
        req = 4'b0011;
        #2;
        rst = 1'b0;
        push(t + 6, 4'b0000, 4'd0, 4'b0000);
        push(t + 7, 4'b0001, 4'd0, 4'b0000);
        push(t + 8, 4'b0000, 4'd0, 4'b0000);
        step(1);
        req = 4'b0000;
        step(3);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain %0d expected entries left, want 0", sb.size());
        end
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
